// File: rtl/param_reg_bank.sv
// Parametrised register bank: NUM_REGS x WIDTH registers, shared function select,
// active-low per-register enables, two combinational read ports, sticky WrapFlag.
// Optional macro REG_BANK_BYPASS_EN forwards load data I to a read port in the load cycle.
module param_reg_bank #(
    parameter int              NUM_REGS  = 4,
    parameter int              WIDTH     = 8,
    parameter int              SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             SEL_W     = (NUM_REGS <= 2) ? 1 : $clog2(NUM_REGS)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [1:0]          FunSel,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [WIDTH-1:0]    I,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    input  logic                FlagClr,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic                WrapFlag
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        FN_DEC   = 2'b00,
        FN_INC   = 2'b01,
        FN_LOAD  = 2'b10,
        FN_CLEAR = 2'b11
    } fun_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             wrap_q;
    logic             wrap_d;
    logic             boundary;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wrap_q <= wrap_d;
        end
    end

    // A boundary event on any enabled register sets the flag even when FlagClr is high.
    always_comb begin
        regs_d   = regs_q;
        boundary = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (!RegSel[k]) begin
                case (fun_e'(FunSel))
                    FN_DEC: begin
                        if (regs_q[k] == '0) begin
                            boundary  = 1'b1;
                            regs_d[k] = (SATURATE != 0) ? '0 : ALL_ONES;
                        end else begin
                            regs_d[k] = regs_q[k] - ONE;
                        end
                    end
                    FN_INC: begin
                        if (regs_q[k] == ALL_ONES) begin
                            boundary  = 1'b1;
                            regs_d[k] = (SATURATE != 0) ? ALL_ONES : '0;
                        end else begin
                            regs_d[k] = regs_q[k] + ONE;
                        end
                    end
                    FN_LOAD:  regs_d[k] = I;
                    default:  regs_d[k] = '0;
                endcase
            end
        end
        wrap_d = boundary | (wrap_q & ~FlagClr);
    end

    // Out-of-range selects match no register and read as zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OutASel == SEL_W'(k)) OutA = regs_q[k];
            if (OutBSel == SEL_W'(k)) OutB = regs_q[k];
`ifdef REG_BANK_BYPASS_EN
            if (FunSel == FN_LOAD && !RegSel[k]) begin
                if (OutASel == SEL_W'(k)) OutA = I;
                if (OutBSel == SEL_W'(k)) OutB = I;
            end
`endif
        end
    end

    assign WrapFlag = wrap_q;

endmodule
